// File: rtl/sort_frame_tx_pkg.sv
// Shared definitions for the sorter frame transmitter: widths, frame length
// and the FSM state encoding.
package sort_frame_tx_pkg;

  localparam int SORT_W      = 8;
  localparam int FRAME_BEATS = 5;
  localparam int IDX_W       = 3;

  // Index of the checksum trailer, the last beat of a frame.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BEATS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/sort_frame_tx_if.sv
// Valid/ready byte stream carrying one sorter frame: four data beats followed
// by an XOR trailer flagged with dout_last.
interface sort_frame_tx_if
  import sort_frame_tx_pkg::*;
#(
  parameter int W = SORT_W
) ();

  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;

  modport master (
    output dout,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );

endinterface

// File: rtl/sort_frame_tx_minmax4.sv
// Combinational minimum and maximum of four unsigned values, used to derive
// the spread of a captured sorter snapshot.
module sort_minmax4
  import sort_frame_tx_pkg::*;
#(
  parameter int W = SORT_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] minV,
  output logic [W-1:0] maxV
);

  logic [W-1:0] minAb;
  logic [W-1:0] maxAb;
  logic [W-1:0] minCd;
  logic [W-1:0] maxCd;

  // Two-level compare tree: pairwise first, then the pair winners.
  always_comb begin
    minAb = (a < b) ? a : b;
    maxAb = (a < b) ? b : a;
    minCd = (c < d) ? c : d;
    maxCd = (c < d) ? d : c;
    minV  = (minAb < minCd) ? minAb : minCd;
    maxV  = (maxAb < maxCd) ? maxCd : maxAb;
  end

endmodule

// File: rtl/sort_frame_tx.sv
// Snapshot serialiser for the four-register sorter. A snap in IDLE captures
// ra..rd, their XOR checksum and their spread, then streams the frame as
// five valid/ready beats. All interface outputs come straight from flops.
module sort_frame_tx
  import sort_frame_tx_pkg::*;
#(
  parameter int W = SORT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [W-1:0]    ra,
  input  logic [W-1:0]    rb,
  input  logic [W-1:0]    rc,
  input  logic [W-1:0]    rd,
  input  logic            snap,
  sort_frame_tx_if.master tx,
  output logic            busy,
  output logic [W-1:0]    frame_range,
  output logic            overrun
);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [W-1:0]     beatBuf_q [0:3];
  logic [W-1:0]     chk_q;
  logic [W-1:0]     chk_d;
  logic [W-1:0]     range_q;
  logic [W-1:0]     range_d;
  logic [W-1:0]     dout_q;
  logic [W-1:0]     beat_d;
  logic             valid_q;
  logic             last_q;
  logic             overrun_q;
  logic [W-1:0]     minV;
  logic [W-1:0]     maxV;

  sort_minmax4 #(.W(W)) u_minmax (
    .a    (ra),
    .b    (rb),
    .c    (rc),
    .d    (rd),
    .minV (minV),
    .maxV (maxV)
  );

  // Next beat index and the value that beat will present, plus capture values.
  always_comb begin
    idx_d   = idx_q + IDX_W'(1);
    beat_d  = (idx_d == LAST_IDX) ? chk_q : beatBuf_q[idx_d[1:0]];
    chk_d   = ra ^ rb ^ rc ^ rd;
    range_d = maxV - minV;
  end

  // Frame FSM: capture on snap, advance one beat per accepted transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      beatBuf_q[0] <= '0;
      beatBuf_q[1] <= '0;
      beatBuf_q[2] <= '0;
      beatBuf_q[3] <= '0;
      chk_q        <= '0;
      range_q      <= '0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (snap) begin
            beatBuf_q[0] <= ra;
            beatBuf_q[1] <= rb;
            beatBuf_q[2] <= rc;
            beatBuf_q[3] <= rd;
            chk_q        <= chk_d;
            range_q      <= range_d;
            idx_q        <= '0;
            dout_q       <= ra;
            valid_q      <= 1'b1;
            last_q       <= 1'b0;
            state_q      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (snap) begin
            overrun_q <= 1'b1;
          end
          if (idx_q > LAST_IDX) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (tx.dout_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_IDLE;
              idx_q   <= '0;
              dout_q  <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              idx_q  <= idx_d;
              dout_q <= beat_d;
              last_q <= (idx_d == LAST_IDX);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx.dout       = dout_q;
  assign tx.dout_valid = valid_q;
  assign tx.dout_last  = last_q;
  assign busy          = (state_q == ST_SEND);
  assign frame_range   = range_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_sort_frame_tx.sv
// Directed bench for sort_frame_tx: frames with and without backpressure,
// input changes mid-frame, snaps while busy, reset mid-frame, random frames.
module tb_sort_frame_tx;

  logic       clk;
  logic       reset;
  logic [7:0] ra;
  logic [7:0] rb;
  logic [7:0] rc;
  logic [7:0] rd;
  logic       snap;
  logic       busy;
  logic [7:0] frame_range;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  sort_frame_tx_if #(.W(8)) tx ();

  sort_frame_tx #(.W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .ra          (ra),
    .rb          (rb),
    .rc          (rc),
    .rd          (rd),
    .snap        (snap),
    .tx          (tx),
    .busy        (busy),
    .frame_range (frame_range),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(tx.dout_valid), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy),          32'd0);
    checkOutput({tag, "_dout"},  32'(tx.dout),       32'd0);
    checkOutput({tag, "_last"},  32'(tx.dout_last),  32'd0);
  endtask

  // readyMode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  // snapMask bit k raises snap on the edge where beat k transfers.
  // scramble overwrites ra..rd right after the capture edge.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d, input int readyMode,
                               input logic [4:0] snapMask, input bit scramble);
    logic [7:0] exp [5];
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] vals [4];
    logic       r;
    int         idx;
    vals = '{a, b, c, d};
    exp  = '{a, b, c, d, a ^ b ^ c ^ d};
    mn = a;
    mx = a;
    for (int k = 1; k < 4; k++) begin
      if (vals[k] < mn) mn = vals[k];
      if (vals[k] > mx) mx = vals[k];
    end
    ra = a; rb = b; rc = c; rd = d;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    if (scramble) begin
      ra = 8'h09; rb = 8'h09; rc = 8'h09; rd = 8'h09;
    end
    checkOutput({tag, "_range"}, 32'(frame_range), 32'(mx - mn));
    idx = 0;
    for (int cyc = 0; cyc < 64 && idx < 5; cyc++) begin
      checkOutput({tag, "_valid"}, 32'(tx.dout_valid), 32'd1);
      checkOutput({tag, "_busy"},  32'(busy),          32'd1);
      checkOutput({tag, "_dout"},  32'(tx.dout),       32'(exp[idx]));
      checkOutput({tag, "_last"},  32'(tx.dout_last),  32'(idx == 4));
      case (readyMode)
        0:       r = 1'b1;
        1:       r = ((cyc % 3) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tx.dout_ready = r;
      snap = r ? snapMask[idx] : 1'b0;
      tick();
      snap = 1'b0;
      if (r) idx++;
    end
    checkOutput({tag, "_beats"}, 32'(idx), 32'd5);
    checkIdle({tag, "_end"});
    checkOutput({tag, "_range_hold"}, 32'(frame_range), 32'(mx - mn));
  endtask

  initial begin
    reset = 1'b1;
    snap  = 1'b0;
    ra = '0; rb = '0; rc = '0; rd = '0;
    tx.dout_ready = 1'b0;
    #1 reset = 1'b0;
    #2;
    checkIdle("rst");
    checkOutput("rst_range",   32'(frame_range), 32'd0);
    checkOutput("rst_overrun", 32'(overrun),     32'd0);
    #8 reset = 1'b1;

    // 1: plain frame, ready held high; trailer 0x40, spread 0x30
    tx.dout_ready = 1'b1;
    applyStimulus("t1", 8'h10, 8'h20, 8'h30, 8'h40, 0, 5'b00000, 1'b0);
    checkOutput("t1_range_const", 32'(frame_range), 32'h30);
    checkOutput("t1_overrun",     32'(overrun),     32'd0);

    // 2: backpressure; trailer 0x00, spread 0xFF
    applyStimulus("t2", 8'hFF, 8'h00, 8'h55, 8'hAA, 1, 5'b00000, 1'b0);
    checkOutput("t2_range_const", 32'(frame_range), 32'hFF);

    // 3: inputs change during SEND; frame still 1,2,3,4 with trailer 0x04
    applyStimulus("t3", 8'h01, 8'h02, 8'h03, 8'h04, 0, 5'b00000, 1'b1);
    checkOutput("t3_overrun", 32'(overrun), 32'd0);

    // 4: snap during beat 2 and on the trailer transfer is ignored
    applyStimulus("t4", 8'h33, 8'h11, 8'h99, 8'h22, 0, 5'b10100, 1'b0);
    checkOutput("t4_overrun", 32'(overrun), 32'd1);
    tick();
    checkIdle("t4_nostart");
    checkOutput("t4_overrun_sticky", 32'(overrun), 32'd1);
    applyStimulus("t4b", 8'h05, 8'h06, 8'h07, 8'h08, 0, 5'b00000, 1'b0);
    checkOutput("t4b_overrun", 32'(overrun), 32'd1);

    // 5: reset mid-frame clears everything immediately
    ra = 8'hA1; rb = 8'hB2; rc = 8'hC3; rd = 8'hD4;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tx.dout_ready = 1'b1;
    tick();
    tick();
    checkOutput("t5_beat2", 32'(tx.dout), 32'hC3);
    #2 reset = 1'b0;
    #1;
    checkIdle("t5_rst");
    checkOutput("t5_rst_range",   32'(frame_range), 32'd0);
    checkOutput("t5_rst_overrun", 32'(overrun),     32'd0);
    #3 reset = 1'b1;
    applyStimulus("t5b", 8'h80, 8'h7F, 8'h01, 8'hFE, 0, 5'b00000, 1'b0);
    checkOutput("t5b_overrun", 32'(overrun), 32'd0);

    // 6: random frames with random idle gaps and random ready
    for (int f = 0; f < 12; f++) begin
      tx.dout_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus("soak", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    2, 5'b00000, 1'b0);
    end
    checkOutput("soak_overrun", 32'(overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
